// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with grant hold, programmable hold timeout and
// binary grant index for direct datapath mux select.
// The owner-release input is named rel because release is a reserved word.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b0}};

  state_t           state_r;
  logic [2:0]       ptr_r;
  logic [2:0]       owner_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [7:0]       gnt_r;
  logic [2:0]       gnt_idx_r;
  logic             gnt_valid_r;
  logic             timeout_r;

  logic             pick_found_s;
  logic [2:0]       pick_idx_s;
  logic             hold_last_s;
  logic             exit_s;
  logic             exit_timeout_s;
  logic             cnt_sat_s;

  // First set bit of r searching p, p+1, ..., p+7 modulo 8; MSB flags a hit.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    // Walk from the lowest priority up so the highest-priority hit is kept.
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      res = r[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // Rotating-priority selection of the next owner.
  always_comb begin
    {pick_found_s, pick_idx_s} = rr_pick(req, ptr_r);
  end

  // Exit decision while granted: release beats implicit release beats timeout.
  always_comb begin
    hold_last_s    = HOLD_EN && (hold_cnt_r == HOLD_LAST);
    cnt_sat_s      = &hold_cnt_r;
    if (state_r == GRANT) begin
      exit_s         = rel || !req[owner_r] || hold_last_s;
      exit_timeout_s = !rel && req[owner_r] && hold_last_s;
    end else begin
      exit_s         = 1'b0;
      exit_timeout_s = 1'b0;
    end
  end

  // Arbiter state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= 3'd0;
      owner_r     <= 3'd0;
      hold_cnt_r  <= {CNT_W{1'b0}};
      gnt_r       <= 8'h00;
      gnt_idx_r   <= 3'd0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          timeout_r <= 1'b0;
          if (pick_found_s) begin
            state_r     <= GRANT;
            owner_r     <= pick_idx_s;
            hold_cnt_r  <= {CNT_W{1'b0}};
            gnt_r       <= 8'h01 << pick_idx_s;
            gnt_idx_r   <= pick_idx_s;
            gnt_valid_r <= 1'b1;
          end else begin
            gnt_r       <= 8'h00;
            gnt_idx_r   <= 3'd0;
            gnt_valid_r <= 1'b0;
          end
        end
        GRANT: begin
          if (exit_s) begin
            state_r     <= IDLE;
            ptr_r       <= owner_r + 3'd1;
            hold_cnt_r  <= {CNT_W{1'b0}};
            gnt_r       <= 8'h00;
            gnt_idx_r   <= 3'd0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= exit_timeout_s;
          end else begin
            timeout_r <= 1'b0;
            // Saturate rather than wrap when the timeout is disabled.
            if (!cnt_sat_s) begin
              hold_cnt_r <= hold_cnt_r + CNT_W'(1);
            end else begin
              hold_cnt_r <= hold_cnt_r;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          gnt_r       <= 8'h00;
          gnt_idx_r   <= 3'd0;
          gnt_valid_r <= 1'b0;
          timeout_r   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = gnt_valid_r;
  assign timeout   = timeout_r;

  rr_arbiter8_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .gnt       (gnt_r),
    .gnt_idx   (gnt_idx_r),
    .gnt_valid (gnt_valid_r),
    .timeout   (timeout_r)
  );

endmodule

// Output consistency properties for rr_arbiter8.
module rr_arbiter8_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [7:0] gnt,
  input logic [2:0] gnt_idx,
  input logic       gnt_valid,
  input logic       timeout
);

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_valid:  assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
  a_idx:    assert property (@(posedge clk) disable iff (!rst_n)
                             gnt_valid |-> (gnt == (8'h01 << gnt_idx)));
  a_idle:   assert property (@(posedge clk) disable iff (!rst_n)
                             !gnt_valid |-> (gnt_idx == 3'd0));
  a_tmo:    assert property (@(posedge clk) disable iff (!rst_n) timeout |-> !gnt_valid);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed testbench for rr_arbiter8: one instance with MAX_HOLD=16 and one
// with the timeout disabled, sharing stimulus.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       rel = 1'b0;

  logic [7:0] gnt, gnt0;
  logic [2:0] gnt_idx, gnt_idx0;
  logic       gnt_valid, gnt_valid0;
  logic       timeout, timeout0;

  wire [12:0] obs  = {gnt, gnt_idx, gnt_valid, timeout};
  wire [12:0] obs0 = {gnt0, gnt_idx0, gnt_valid0, timeout0};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  rr_arbiter8 #(.MAX_HOLD(0), .CNT_W(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .gnt(gnt0), .gnt_idx(gnt_idx0), .gnt_valid(gnt_valid0), .timeout(timeout0)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    rel   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    rel   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== 13'h0) begin bad++; $display("FAIL reset_dut got=%h exp=%h", obs, 13'h0); end
    total++;
    if (obs0 !== 13'h0) begin bad++; $display("FAIL reset_dut0 got=%h exp=%h", obs0, 13'h0); end
    req   = 8'h00;
    rst_n = 1'b1;
    step();
    total++;
    if (obs !== 13'h0) begin bad++; $display("FAIL idle_after_reset got=%h exp=%h", obs, 13'h0); end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h04;
    step();
    total++;
    if (obs0 !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
      bad++; $display("FAIL single_grant got=%h exp=%h", obs0, {8'h04, 3'd2, 1'b1, 1'b0});
    end
    for (int c = 0; c < 40; c++) begin
      step();
      total++;
      if (obs0 !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
        bad++; $display("FAIL single_hold cyc=%0d got=%h exp=%h", c, obs0, {8'h04, 3'd2, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_fairness();
    logic [2:0] e;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      e = 3'(k % 8);
      step();
      total++;
      if (obs !== {8'h01 << e, e, 1'b1, 1'b0}) begin
        bad++; $display("FAIL rr_grant k=%0d got=%h exp=%h", k, obs, {8'h01 << e, e, 1'b1, 1'b0});
      end
      total++;
      if (gnt_idx0 !== e) begin
        bad++; $display("FAIL rr_grant0 k=%0d got=%0d exp=%0d", k, gnt_idx0, e);
      end
      rel = 1'b1;
      step();
      rel = 1'b0;
      total++;
      if (obs !== 13'h0) begin bad++; $display("FAIL rr_idle k=%0d got=%h exp=%h", k, obs, 13'h0); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h80;
    step();
    total++;
    if (obs !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
      bad++; $display("FAIL wrap_g7 got=%h exp=%h", obs, {8'h80, 3'd7, 1'b1, 1'b0});
    end
    req = 8'h81;
    rel = 1'b1;
    step();
    rel = 1'b0;
    step();
    total++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL wrap_g0 got=%h exp=%h", obs, {8'h01, 3'd0, 1'b1, 1'b0});
    end
    rel = 1'b1;
    step();
    rel = 1'b0;
    step();
    total++;
    if (obs !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
      bad++; $display("FAIL wrap_g7b got=%h exp=%h", obs, {8'h80, 3'd7, 1'b1, 1'b0});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h03;
    step();
    total++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL tmo_first got=%h exp=%h", obs, {8'h01, 3'd0, 1'b1, 1'b0});
    end
    for (int c = 1; c < 16; c++) begin
      step();
      total++;
      if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
        bad++; $display("FAIL tmo_hold cyc=%0d got=%h exp=%h", c, obs, {8'h01, 3'd0, 1'b1, 1'b0});
      end
    end
    step();
    total++;
    if (obs !== {8'h00, 3'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL tmo_pulse got=%h exp=%h", obs, {8'h00, 3'd0, 1'b0, 1'b1});
    end
    step();
    total++;
    if (obs !== {8'h02, 3'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL tmo_next got=%h exp=%h", obs, {8'h02, 3'd1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 8'h01;
    step();
    repeat (15) step();
    total++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sim_hold15 got=%h exp=%h", obs, {8'h01, 3'd0, 1'b1, 1'b0});
    end
    req = 8'h00;
    step();
    total++;
    if (obs !== 13'h0) begin bad++; $display("FAIL sim_drop_no_tmo got=%h exp=%h", obs, 13'h0); end
    step();
    total++;
    if (obs !== 13'h0) begin bad++; $display("FAIL sim_drop_idle got=%h exp=%h", obs, 13'h0); end

    do_reset();
    req = 8'h03;
    step();
    rel = 1'b1;
    req = 8'h02;
    step();
    rel = 1'b0;
    req = 8'h03;
    total++;
    if (obs !== 13'h0) begin bad++; $display("FAIL sim_both_exit got=%h exp=%h", obs, 13'h0); end
    step();
    total++;
    if (obs !== {8'h02, 3'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sim_ptr_once got=%h exp=%h", obs, {8'h02, 3'd1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h20;
    step();
    total++;
    if (obs !== {8'h20, 3'd5, 1'b1, 1'b0}) begin
      bad++; $display("FAIL mid_g5 got=%h exp=%h", obs, {8'h20, 3'd5, 1'b1, 1'b0});
    end
    req = 8'h21;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 13'h0) begin bad++; $display("FAIL mid_async_drop got=%h exp=%h", obs, 13'h0); end
    total++;
    if (obs0 !== 13'h0) begin bad++; $display("FAIL mid_async_drop0 got=%h exp=%h", obs0, 13'h0); end
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL mid_ptr_restored got=%h exp=%h", obs, {8'h01, 3'd0, 1'b1, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter that shares one downstream resource between eight requesters. It grants exactly one requester at a time and holds the grant until the owner releases, drops its request, or exceeds a programmable hold limit. After each grant it rotates priority so every requester is served. It drives the grant index as a 3-bit binary code alongside the one-hot grant, so the downstream datapath mux selects directly from it.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles a single grant may be held; 0 disables the timeout.
- CNT_W, 5: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.
- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low; one clock, no other clock domain.
- req  input  8  request vector; bit i = requester i wants the resource.
- release  input  1  current owner finished; sampled only in GRANT.
- gnt  output  8  one-hot grant, registered; all zeros when idle.
- gnt_idx  output  3  binary index of granted requester, registered; 0 when idle.
- gnt_valid  output  1  high while any grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

## Operation
- State machine has two states:
  - **IDLE**: no grant.
  - **GRANT**: one owner is held in the owner register.
- Priority pointer ptr[2:0] marks the highest-priority requester. Search order is ptr, ptr+1, …, ptr+7, modulo 8.
- IDLE:
  - If req != 0, select the first set bit in search order, load the owner, go to GRANT, and clear hold_cnt to 0.
  - If req == 0, stay in IDLE with outputs at zero.
- GRANT: each cycle, evaluate the exit conditions in this priority order:
  1. release == 1 → exit. No timeout pulse.
  2. req[owner] == 0 → exit. Treated as an implicit release; no timeout pulse.
  3. MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1 → exit and pulse timeout.
  4. Otherwise hold_cnt increments. The counter saturates and never wraps.
- On any exit:
  - ptr <= owner+1 modulo 8. Owner 7 wraps ptr to 0.
  - State returns to IDLE.
- A preempted (timed-out) requester that keeps req high competes again at lowest priority.
- Changes to req bits of non-owners during GRANT have no effect.
- Reset values: state IDLE, ptr 0, owner 0, hold_cnt 0, gnt 8'h00, gnt_idx 3'b000, gnt_valid 0, timeout 0.
- After reset, ptr = 0, so requester 0 has highest priority and requester 7 lowest.
- Asserting rst_n low mid-grant drops gnt, gnt_valid and gnt_idx immediately (asynchronously) and restores ptr to 0.

## Timing
- Request-to-grant latency: req sampled at edge t in IDLE → gnt/gnt_idx/gnt_valid valid after edge t, through cycle t+1.
- Release latency: release sampled at edge t → gnt low from edge t onward. The state is IDLE during that cycle and arbitration uses req sampled at edge t+1, so the next grant appears after edge t+1.
- Back-to-back grants are therefore separated by exactly one idle cycle.
- Timeout: gnt is high for exactly MAX_HOLD cycles. The timeout pulse is high in the first idle cycle after revocation, one cycle wide.
- release asserted while in IDLE is ignored.
- All outputs are registered; there are no combinational paths from req or release to any output.

## Test plan
- **Reset and single request**:
  - Stimulus: after reset, req=8'h04 held, release never asserted, MAX_HOLD=0.
  - Required: gnt=8'h04, gnt_idx=2, gnt_valid=1 one cycle after req; held indefinitely; timeout never pulses.
- **Round-robin fairness**:
  - Stimulus: req=8'hFF held; release pulsed one cycle after each grant appears.
  - Required: gnt_idx sequence 0,1,2,…,7,0 with one idle cycle between grants.
- **Pointer wrap**:
  - Stimulus: grant to 7 then release, with req=8'h81.
  - Required: next grant to 0. Then with req=8'h81 again, next grant to 7.
- **Timeout**:
  - Stimulus: MAX_HOLD=16, req=8'h03 held, no release.
  - Required: requester 0 granted 16 cycles, timeout pulses once, then requester 1 granted after one idle cycle.
- **Implicit release and simultaneous events**:
  - Stimulus 1: owner drops req on the same cycle hold_cnt reaches 15.
  - Required 1: grant ends, timeout stays 0.
  - Stimulus 2: release and req[owner]=0 together.
  - Required 2: one exit, ptr advances once.
- **Reset mid-grant**:
  - Stimulus: gnt_idx=5 active, rst_n pulsed low between clock edges.
  - Required: gnt=0 immediately. After rst_n is released with req=8'h21, grant goes to 0 (bit 0 priority restored), not to 5.
